// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, waits MEM_LATENCY cycles per fetch,
// buffers one instruction for decode, and handles redirects and address faults.
module fetch_controller #(
   parameter int          MEM_WORDS   = 64,
   parameter int          MEM_LATENCY = 1,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fault,
   output logic [15:0] instr_count
);

   localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
   localparam logic [2:0]  LAT_LAST  = 3'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {REQ, VALID, FAULT} state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [2:0]  lat_reg, lat_next;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] opc_reg, opc_next;
   logic [15:0] count_reg, count_next;
   logic        redirect_ok;

   assign redirect_ok = (redirect_pc[1:0] == 2'b00) && (redirect_pc < MEM_BYTES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= REQ;
         pc_reg    <= RESET_PC;
         lat_reg   <= 3'd0;
         instr_reg <= 32'd0;
         opc_reg   <= 32'd0;
         count_reg <= 16'd0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         lat_reg   <= lat_next;
         instr_reg <= instr_next;
         opc_reg   <= opc_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      lat_next   = lat_reg;
      instr_next = instr_reg;
      opc_next   = opc_reg;
      count_next = count_reg;

      case (state_reg)
         REQ: begin
            if (lat_reg == LAT_LAST) begin
               instr_next = imem_rdata;
               opc_next   = pc_reg;
               pc_next    = pc_reg + 32'd4;
               lat_next   = 3'd0;
               state_next = VALID;
            end else begin
               lat_next = lat_reg + 3'd1;
            end
         end
         VALID: begin
            if (out_ready) begin
               count_next = count_reg + 16'd1;
               state_next = (pc_reg < MEM_BYTES) ? REQ : FAULT;
            end
         end
         default: ;
      endcase

      // Redirect overrides sequencing, but a handshake in the same cycle still counts.
      if (redirect_valid) begin
         instr_next = instr_reg;
         opc_next   = opc_reg;
         pc_next    = redirect_pc;
         lat_next   = 3'd0;
         state_next = redirect_ok ? REQ : FAULT;
      end
   end

   assign imem_addr   = pc_reg;
   assign imem_req    = (state_reg == REQ);
   assign out_valid   = (state_reg == VALID);
   assign fault       = (state_reg == FAULT);
   assign out_instr   = instr_reg;
   assign out_pc      = opc_reg;
   assign instr_count = count_reg;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: two instances (latency 1 and 3) driven by the same
// directed and random stimulus, each checked every cycle against a behavioural model.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_ready;

   logic [31:0] addr_a, rdata_a, instr_a, opc_a;
   logic        req_a, valid_a, fault_a;
   logic [15:0] cnt_a;
   logic [31:0] addr_b, rdata_b, instr_b, opc_b;
   logic        req_b, valid_b, fault_b;
   logic [15:0] cnt_b;

   logic [31:0] mem [64];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign rdata_a = mem[addr_a[7:2]];
   assign rdata_b = mem[addr_b[7:2]];

   fetch_controller #(.MEM_WORDS(64), .MEM_LATENCY(1), .RESET_PC(32'h0)) dut_a (
      .clk(clk), .rst_n(rst_n), .imem_addr(addr_a), .imem_req(req_a),
      .imem_rdata(rdata_a), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(valid_a), .out_ready(out_ready), .out_instr(instr_a), .out_pc(opc_a),
      .fault(fault_a), .instr_count(cnt_a));

   fetch_controller #(.MEM_WORDS(64), .MEM_LATENCY(3), .RESET_PC(32'h0)) dut_b (
      .clk(clk), .rst_n(rst_n), .imem_addr(addr_b), .imem_req(req_b),
      .imem_rdata(rdata_b), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(valid_b), .out_ready(out_ready), .out_instr(instr_b), .out_pc(opc_b),
      .fault(fault_b), .instr_count(cnt_b));

   // Model: a PC, an optional buffered instruction, a fault flag and a wait counter.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] ipc;
      bit          buffered;
      bit          faulted;
      int          waited;
      logic [15:0] count;
   } model_t;

   model_t ma, mb;

   function automatic model_t mreset();
      model_t m;
      m.pc = 32'h0; m.instr = 32'h0; m.ipc = 32'h0;
      m.buffered = 1'b0; m.faulted = 1'b0; m.waited = 0; m.count = 16'h0;
      return m;
   endfunction

   function automatic model_t mstep(model_t m, int lat, bit rv, logic [31:0] rpc, bit rdy);
      model_t n = m;
      if (rv) begin
         if (m.buffered && rdy) n.count = m.count + 16'd1;
         n.buffered = 1'b0;
         n.waited   = 0;
         n.pc       = rpc;
         n.faulted  = (rpc % 4 != 0) || (rpc >= 32'd256);
      end else if (m.faulted) begin
         n = m;
      end else if (m.buffered) begin
         if (rdy) begin
            n.count    = m.count + 16'd1;
            n.buffered = 1'b0;
            n.faulted  = (m.pc >= 32'd256);
         end
      end else begin
         n.waited = m.waited + 1;
         if (n.waited == lat) begin
            n.instr    = mem[m.pc / 4];
            n.ipc      = m.pc;
            n.pc       = m.pc + 32'd4;
            n.waited   = 0;
            n.buffered = 1'b1;
         end
      end
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic cmp_dut(input string tag, input model_t m, input logic [31:0] addr,
                          input logic req, input logic ov, input logic [31:0] oi,
                          input logic [31:0] opc, input logic f, input logic [15:0] cnt);
      chk({tag, ".imem_addr"}, addr, m.pc);
      chk({tag, ".imem_req"}, 32'(req), 32'(!m.buffered && !m.faulted));
      chk({tag, ".out_valid"}, 32'(ov), 32'(m.buffered));
      chk({tag, ".fault"}, 32'(f), 32'(m.faulted));
      chk({tag, ".instr_count"}, 32'(cnt), 32'(m.count));
      if (m.buffered) begin
         chk({tag, ".out_instr"}, oi, m.instr);
         chk({tag, ".out_pc"}, opc, m.ipc);
      end
   endtask

   task automatic compare_all();
      cmp_dut("lat1", ma, addr_a, req_a, valid_a, instr_a, opc_a, fault_a, cnt_a);
      cmp_dut("lat3", mb, addr_b, req_b, valid_b, instr_b, opc_b, fault_b, cnt_b);
   endtask

   // Called at a falling edge: drive inputs, advance models at the rising edge, check at the next fall.
   task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      @(posedge clk);
      ma = mstep(ma, 1, rv, rpc, rdy);
      mb = mstep(mb, 3, rv, rpc, rdy);
      @(negedge clk);
      $display("[TB] cyc rv=%0d rpc=%h rdy=%0d | lat1 pc=%h v=%0d f=%0d n=%0d | lat3 pc=%h v=%0d f=%0d n=%0d",
               rv, rpc, rdy, addr_a, valid_a, fault_a, cnt_a, addr_b, valid_b, fault_b, cnt_b);
      compare_all();
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      ma = mreset();
      mb = mreset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] saved;
      logic [31:0] rpc;
      int sel;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
      ma = mreset(); mb = mreset();
      @(negedge clk);
      @(negedge clk);
      compare_all();
      chk("reset.imem_addr", addr_a, 32'h0);
      chk("reset.out_valid", 32'(valid_b), 32'h0);
      rst_n = 1'b1;

      // Sequential fetch with decode always ready.
      for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);
      chk("seq.count4", 32'(cnt_a), 32'd4);
      chk("seq.next_pc", addr_a, 32'h10);

      // Backpressure: hold an instruction for five cycles, then release.
      cycle(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
      chk("bp.out_pc", opc_a, 32'h10);
      chk("bp.out_instr", instr_a, mem[4]);
      chk("bp.imem_req", 32'(req_a), 32'h0);
      chk("bp.pc", addr_a, 32'h14);
      cycle(1'b0, 32'h0, 1'b1);
      chk("bp.count5", 32'(cnt_a), 32'd5);

      // Redirect while VALID with out_pc=8, without and then with a handshake.
      cycle(1'b1, 32'h8, 1'b0);
      cycle(1'b0, 32'h0, 1'b0);
      chk("redir.out_pc8", opc_a, 32'h8);
      saved = cnt_a;
      cycle(1'b1, 32'h0, 1'b0);
      chk("redir.valid0", 32'(valid_a), 32'h0);
      chk("redir.addr0", addr_a, 32'h0);
      chk("redir.count_same", 32'(cnt_a), 32'(saved));
      cycle(1'b0, 32'h0, 1'b0);
      chk("redir.out_pc0", opc_a, 32'h0);
      cycle(1'b1, 32'h0, 1'b1);
      chk("redir.count_inc", 32'(cnt_a), 32'(saved + 16'd1));

      // Faults: misaligned, out of range, then recovery.
      cycle(1'b1, 32'h6, 1'b0);
      chk("flt.mis", 32'(fault_a), 32'h1);
      chk("flt.req", 32'(req_a), 32'h0);
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b1, 32'h100, 1'b0);
      chk("flt.range", 32'(fault_b), 32'h1);
      cycle(1'b1, 32'h4, 1'b0);
      chk("flt.clear", 32'(fault_a), 32'h0);
      cycle(1'b0, 32'h0, 1'b0);
      chk("flt.word1", instr_a, mem[1]);

      // End of memory: the last word is delivered, the advance past it faults.
      cycle(1'b1, 32'hFC, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      chk("end.fault", 32'(fault_a), 32'h1);
      chk("end.addr", addr_a, 32'h100);
      chk("end.req", 32'(req_a), 32'h0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);
      chk("end.fault3", 32'(fault_b), 32'h1);

      // Asynchronous reset while the latency-3 instance is mid-request.
      cycle(1'b1, 32'h20, 1'b0);
      cycle(1'b0, 32'h0, 1'b0);
      chk("rst.pre_req", 32'(req_b), 32'h1);
      pulse_reset();
      chk("rst.addr", addr_b, 32'h0);
      chk("rst.count", 32'(cnt_b), 32'h0);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            6:       rpc = 32'($urandom_range(0, 255)) | 32'h1;
            7:       rpc = 32'hFC;
            8:       rpc = 32'h100 + (32'($urandom_range(0, 1000)) << 2);
            9:       rpc = $urandom;
            default: rpc = 32'($urandom_range(0, 63)) << 2;
         endcase
         if (i == 400) pulse_reset();
         cycle($urandom_range(0, 99) < 8, rpc, $urandom_range(0, 99) < 70);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
